// File: rtl/first_match_pkg.sv
// Shared types and default sizing for the first-match stimulus generator
// and its response monitor.
package first_match_pkg;

  localparam int FMG_WINDOW   = 5;
  localparam int FMG_RESP_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    REPORT
  } fmg_state_e;

  typedef enum logic [1:0] {
    OUT_NONE,
    OUT_MATCH,
    OUT_FAIL
  } fm_outcome_e;

endpackage

// File: rtl/first_match_resp_mon.sv
// Records the first match/fail response in a capture window and flags
// duplicate responses and simultaneous match+fail.
module first_match_resp_mon
  import first_match_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        cap,
  input  logic        match_in,
  input  logic        fail_in,
  output fm_outcome_e first_o,
  output logic        dup_o,
  output logic        both_o
);

  fm_outcome_e first_q, first_d;
  logic        dup_q, dup_d;
  logic        both_q, both_d;

  always_comb begin
    first_d = first_q;
    dup_d   = dup_q;
    both_d  = both_q;
    if (clr) begin
      first_d = OUT_NONE;
      dup_d   = 1'b0;
      both_d  = 1'b0;
    end else if (cap) begin
      if (match_in && fail_in) both_d = 1'b1;
      if (match_in || fail_in) begin
        if (first_q == OUT_NONE) first_d = match_in ? OUT_MATCH : OUT_FAIL;
        else                     dup_d   = 1'b1;
      end
    end
  end

  // Outputs already fold in the current cycle, so the last capture cycle
  // can be graded on the same edge that closes the window.
  assign first_o = first_d;
  assign dup_o   = dup_d;
  assign both_o  = both_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= OUT_NONE;
      dup_q   <= 1'b0;
      both_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      dup_q   <= dup_d;
      both_q  <= both_d;
    end
  end

endmodule

// File: rtl/first_match_gen.sv
// Drives one en/signal_in window into a first-match checker, grades the
// checker's response and keeps a saturating error count.
module first_match_gen
  import first_match_pkg::*;
#(
  parameter int WINDOW   = FMG_WINDOW,
  parameter int RESP_MAX = FMG_RESP_MAX,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       delay,
  input  logic             no_hit,
  input  logic             extra_hits,
  output logic             ready,
  output logic             en_out,
  output logic             sig_out,
  input  logic             match_in,
  input  logic             fail_in,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(RESP_MAX + 1);

  fmg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dly_q, dly_d;
  logic             hit_q, hit_d;
  logic             extra_q, extra_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             sig_q, sig_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;

  fm_outcome_e      first;
  logic             dup, both, cap, grade;
  logic [CNT_W-1:0] dly_ext;

  // cnt_q equals the window index k while driving and keeps counting
  // through WAIT, so indices 1..RESP_MAX are the response capture cycles.
  assign cap = ((state_q == DRIVE) || (state_q == WAIT)) && (cnt_q != '0);

  first_match_resp_mon u_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (en_q),
    .cap      (cap),
    .match_in (match_in),
    .fail_in  (fail_in),
    .first_o  (first),
    .dup_o    (dup),
    .both_o   (both)
  );

  assign grade = (first == (hit_q ? OUT_MATCH : OUT_FAIL)) && !dup && !both;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    hit_d   = hit_q;
    extra_d = extra_q;
    ready_d = ready_q;
    pass_d  = pass_q;
    err_d   = err_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    sig_d   = 1'b0;
    dly_ext = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = '0;
          dly_d   = delay;
          hit_d   = !no_hit && (int'(delay) < WINDOW);
          extra_d = extra_hits;
          en_d    = 1'b1;
          ready_d = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WINDOW - 1)) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RESP_MAX)) begin
          state_d = REPORT;
          done_d  = 1'b1;
          pass_d  = grade;
          if (!grade && (err_q != '1)) err_d = err_q + ERR_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Signal level for the index about to be presented.
    if (state_d == DRIVE) begin
      dly_ext = CNT_W'(dly_d);
      sig_d   = hit_d && ((cnt_d == dly_ext) || ((cnt_d > dly_ext) && extra_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    dly_q   <= dly_d;
    hit_q   <= hit_d;
    extra_q <= extra_d;
  end

  assign ready   = ready_q;
  assign en_out  = en_q;
  assign sig_out = sig_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_first_match_gen.sv
// Directed bench for first_match_gen with a scripted checker responder.
module tb_first_match_gen;

  localparam int W = 5;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] delay = 3'd0;
  logic       no_hit = 1'b0;
  logic       extra_hits = 1'b0;
  logic       match_in = 1'b0;
  logic       fail_in = 1'b0;
  logic       ready, en_out, sig_out, done, pass;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  first_match_gen #(.WINDOW(W), .RESP_MAX(R), .ERR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .delay      (delay),
    .no_hit     (no_hit),
    .extra_hits (extra_hits),
    .ready      (ready),
    .en_out     (en_out),
    .sig_out    (sig_out),
    .match_in   (match_in),
    .fail_in    (fail_in),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // rmode: 0 silent, 1 match, 2 fail, 3 match+fail together.
  // rc/rc2: cycles after the en cycle at which the responder pulses (-1 = none).
  task automatic run_txn(input logic [2:0] d, input logic nh, input logic ex,
                         input int rmode, input int rc, input int rc2,
                         input logic [4:0] exp_sig, input logic exp_pass,
                         input bit poke);
    if (!exp_pass && exp_err < 255) exp_err++;
    @(negedge clk);
    chk("ready_idle", ready, 1);
    start = 1'b1; delay = d; no_hit = nh; extra_hits = ex;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= R + 2; c++) begin
      chk("sig_out", sig_out, (c < W) ? exp_sig[c] : 1'b0);
      chk("en_out", en_out, (c == 0));
      chk("ready", ready, (c == R + 2));
      chk("done", done, (c == R + 1));
      if (c == R + 1) begin
        chk("pass", pass, exp_pass);
        chk("err_cnt", err_cnt, exp_err);
      end
      match_in = ((c == rc) || (c == rc2)) && (rmode == 1 || rmode == 3);
      fail_in  = ((c == rc) || (c == rc2)) && (rmode == 2 || rmode == 3);
      start    = poke && (c == 2 || c == 6);
      if (c < R + 2) @(negedge clk);
    end
    match_in = 1'b0; fail_in = 1'b0; start = 1'b0;
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_en", en_out, 0);
    chk("rst_sig", sig_out, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;

    run_txn(3'd2, 1'b0, 1'b0, 1,  3, -1, 5'b00100, 1'b1, 1'b0);
    run_txn(3'd0, 1'b0, 1'b1, 1,  1, -1, 5'b11111, 1'b1, 1'b0);
    run_txn(3'd0, 1'b0, 1'b1, 1,  1,  4, 5'b11111, 1'b0, 1'b0);
    run_txn(3'd2, 1'b1, 1'b0, 2,  6, -1, 5'b00000, 1'b1, 1'b0);
    run_txn(3'd7, 1'b0, 1'b0, 2,  8, -1, 5'b00000, 1'b1, 1'b0);
    run_txn(3'd3, 1'b0, 1'b0, 0, -1, -1, 5'b01000, 1'b0, 1'b0);
    run_txn(3'd2, 1'b1, 1'b1, 1,  2, -1, 5'b00000, 1'b0, 1'b0);
    run_txn(3'd1, 1'b0, 1'b1, 3,  2, -1, 5'b11110, 1'b0, 1'b0);
    run_txn(3'd4, 1'b0, 1'b0, 1,  5, -1, 5'b10000, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++)
      run_txn(3'd2, 1'b0, 1'b0, 0, -1, -1, 5'b00100, 1'b0, 1'b0);
    chk("err_saturated", err_cnt, 255);

    // start held high: one en pulse every R+3 cycles
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      chk("stream_en", en_out, ((i % (R + 3)) == 1));
    end
    start = 1'b0;
    waited = 0;
    while (!ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("stream_ready_timeout", ready, 1);
    chk("stream_err_sat", err_cnt, 255);

    // reset in the middle of DRIVE at k=3
    @(negedge clk);
    start = 1'b1; delay = 3'd2; no_hit = 1'b0; extra_hits = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_sig", sig_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_en", en_out, 0);
    chk("mid_rst_sig", sig_out, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err_cnt, 0);
    exp_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
    end
    run_txn(3'd2, 1'b0, 1'b0, 1, 3, -1, 5'b00100, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
